// File: rtl/pipe_pkg.sv
// Shared definitions for the 3-stage pipeline controller: state encoding,
// register-address width and the NOP/initial values loaded by the pipeline registers.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MC_WAIT = 2'b10
  } pipe_state_e;

  // Values a pipeline register takes when flushed or bubbled.
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0000;
  localparam logic [REG_W-1:0] NOP_RD    = '0;
  localparam logic [31:0]      PC_INIT   = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// ID-vs-EX register match detection. fwd_a/fwd_b are the rs/rt terms of the
// read-after-write hazard; their OR is the stall condition.
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  output logic             fwd_a,
  output logic             fwd_b
);

  logic wr_live;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign wr_live = ex_regwrite & (ex_rd != '0);
  assign fwd_a   = wr_live & id_uses_rs & (id_rs == ex_rd);
  assign fwd_b   = wr_live & id_uses_rt & (id_rt == ex_rd);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load enables, bubbles, flushes, multi-cycle
// holds and a saturating stall counter. PIPE_CTRL_FORWARD_EN exposes fwd_a/fwd_b
// and turns the RAW stall off.
module pipe_ctrl #(
  parameter int REG_W  = pipe_pkg::REG_W,
  parameter int MC_W   = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_multicycle,
  input  logic [MC_W-1:0]   ex_mc_cycles,
  input  logic              branch_taken,
  output logic              pc_ld,
  output logic              ifid_ld,
  output logic              idex_ld,
  output logic              exwb_ld,
  output logic              ifid_flush,
  output logic              idex_bubble,
`ifdef PIPE_CTRL_FORWARD_EN
  output logic              fwd_a,
  output logic              fwd_b,
`endif
  output logic [1:0]        state,
  output logic [PERF_W-1:0] stall_cycles
);

  import pipe_pkg::*;

  pipe_state_e       state_q, state_d;
  logic [MC_W-1:0]   cnt_q, cnt_d;
  logic              mc_done_q, mc_done_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              hz_a, hz_b;
  logic              mc;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .fwd_a       (hz_a),
    .fwd_b       (hz_b)
  );

`ifdef PIPE_CTRL_FORWARD_EN
  assign fwd_a = hz_a;
  assign fwd_b = hz_b;
`else
  logic raw;
  assign raw = hz_a | hz_b;
`endif

  // mc_done blocks re-triggering the hold for the same EX instruction.
  assign mc = ex_multicycle & (ex_mc_cycles != '0) & ~mc_done_q;

  always_comb begin
    pc_ld       = 1'b0;
    ifid_ld     = 1'b0;
    idex_ld     = 1'b0;
    exwb_ld     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mc_done_d   = mc_done_q;

    if (!run) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      mc_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (mc) begin
            if (ex_mc_cycles == MC_W'(1)) begin
              mc_done_d = 1'b1;
            end else begin
              cnt_d   = ex_mc_cycles - MC_W'(1);
              state_d = ST_MC_WAIT;
            end
          end
`ifndef PIPE_CTRL_FORWARD_EN
          else if (raw) begin
            idex_ld     = 1'b1;
            idex_bubble = 1'b1;
            exwb_ld     = 1'b1;
          end
`endif
          else begin
            pc_ld      = 1'b1;
            ifid_ld    = 1'b1;
            idex_ld    = 1'b1;
            exwb_ld    = 1'b1;
            ifid_flush = branch_taken;
          end
        end
        ST_MC_WAIT: begin
          cnt_d = cnt_q - MC_W'(1);
          if (cnt_q <= MC_W'(1)) begin
            cnt_d     = '0;
            state_d   = ST_RUN;
            mc_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A real instruction entering EX retires the multi-cycle marker.
    if (idex_ld && !idex_bubble) mc_done_d = 1'b0;

    stall_d = stall_q;
    if (run && (state_q != ST_IDLE) && !pc_ld && (stall_q != '1))
      stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mc_done_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_done_q <= mc_done_d;
      stall_q   <= stall_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage MIPS datapath (PC -> IF_ID -> ID_EX -> EX_WB -> register bank).
- Generates the LD enables for the PC and every pipeline register, inserts bubbles and flushes, and holds the pipe during multi-cycle ALU operations.
- Resolves the ID-vs-EX read-after-write hazard by stalling.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register-address width.
- MC_W, 4, width of the multi-cycle latency field.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  pipeline enable; 0 freezes the pipe.
- id_rs  in  REG_W  rs source address of the instruction in ID.
- id_rt  in  REG_W  rt source address of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  REG_W  destination address of the instruction in EX.
- ex_regwrite  in  1  EX instruction writes the register bank.
- ex_multicycle  in  1  EX instruction needs extra cycles.
- ex_mc_cycles  in  MC_W  number of extra cycles N.
- branch_taken  in  1  branch in ID resolved taken.
- pc_ld  out  1  PC load enable.
- ifid_ld  out  1  IF_ID load enable.
- idex_ld  out  1  ID_EX load enable.
- exwb_ld  out  1  EX_WB load enable.
- ifid_flush  out  1  IF_ID loads its NOP/initial value instead of its datain.
- idex_bubble  out  1  ID_EX loads its NOP/initial value instead of its datain.
- state  out  2  00 IDLE, 01 RUN, 10 MC_WAIT.
- stall_cycles  out  PERF_W  saturating count of stall cycles.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, mc_done=0, stall_cycles=0. All load, flush and bubble outputs are 0.
- Outputs are a combinational decode of state, the inputs and mc_done. The enables act on the same clock edge (zero latency).
- run=0: all load/flush/bubble outputs are 0 combinationally. State goes to IDLE at the next edge; cnt and mc_done are cleared.
- IDLE: all outputs 0. With run=1, go to RUN at the next edge.
- Hazard definitions:
  - raw = ex_regwrite & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - mc = ex_multicycle & (ex_mc_cycles!=0) & !mc_done.
- RUN, evaluated in fixed priority order:
  1. mc: all loads 0.
     - N==1: set mc_done and stay in RUN.
     - Otherwise: cnt<=N-1 and go to MC_WAIT.
  2. raw: pc_ld=0, ifid_ld=0, idex_ld=1 with idex_bubble=1, exwb_ld=1.
  3. branch_taken: all loads 1, ifid_flush=1.
  4. Otherwise: all loads 1.
- mc_done is cleared on any edge where idex_ld=1 and idex_bubble=0.
- MC_WAIT: all loads 0; cnt decrements each cycle. When cnt==1: go to RUN and set mc_done. Total hold = exactly N cycles.
- branch_taken and raw are ignored during a multi-cycle hold. ID is held, so both are re-evaluated afterwards.
- ex_mc_cycles==0 means no hold.
- stall_cycles increments on every edge where state is RUN or MC_WAIT, run=1 and pc_ld=0. It saturates at all-ones (no wrap).

Optional Feature:
- Macro: PIPE_CTRL_FORWARD_EN.
- Defined:
  - Adds outputs fwd_a and fwd_b (1 bit each): the rs-match and rt-match terms of raw.
  - raw no longer stalls; RUN priority becomes mc > branch > normal.
- Undefined: the forwarding ports are absent and raw stalls as above.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_MC_WAIT;
  - REG_W and the NOP/initial-value constants used by the pipeline registers.
- One natural sub-module: hazard_detect (combinational raw, fwd_a and fwd_b).

Test Plan:
1. Reset mid-MC_WAIT (cnt=2) -> immediately state=00, all outputs 0, stall_cycles=0; run=1 -> RUN after one edge.
2. id_rs=3, id_uses_rs=1, ex_rd=3, ex_regwrite=1 -> one cycle with pc_ld=0, ifid_ld=0, idex_bubble=1, stall_cycles +1. Same with ex_rd=0 -> no stall.
3. ex_multicycle=1, ex_mc_cycles=3 -> exactly 3 cycles of all loads 0, then a normal advance, stall_cycles +3. Repeat with N=1 -> exactly 1 cycle.
4. Simultaneous branch_taken=1 and mc stall of N=2 -> 2 hold cycles, then ifid_flush=1 with all loads 1.
5. Force stall_cycles to 16'hFFFF, then stall again -> stays at 16'hFFFF.
6. PIPE_CTRL_FORWARD_EN defined, scenario 2 stimulus -> fwd_a=1, no stall, all loads 1.
